hazard_sched: RTL and testbench

- Hazard and stall scheduler for the 5-stage MIPS pipeline.
- Drives the stall/flush enables of the IF/ID, ID/EX and EX/MEM pipeline registers, and the forwarding mux selects in ID and EX.
- Adds sequential tracking of a multi-cycle multiply/divide unit and of data-memory wait states, including a wait watchdog.

---
 rtl/hazard_sched.sv | 156 +++++++++++++++
 tb/tb_hazard_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// Hazard and stall scheduler for the 5-stage MIPS pipeline.
// Resolves data hazards by forwarding where possible and stalling where not.
// Also tracks the multi-cycle HI/LO unit and data-memory wait states, with
// a sticky watchdog flag for memory accesses that never complete.
module hazard_sched #(
  parameter int MD_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MdOpD,
  input  logic       MdStartE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MdBusy,
  output logic       MemErr
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
  localparam logic [3:0]        MD_LOAD    = 4'(MD_LATENCY - 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        md_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_err;

  logic mem_stall;
  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic md_busy;

  assign md_busy = (md_cnt != 4'd0);
  assign MdBusy  = md_busy;
  assign MemErr  = mem_err;

  // Raw hazard terms; a memory wait is recognised in either FSM state.
  always_comb begin
    mem_stall = MemReqM & ~MemReadyM;
    lw_stall  = MemtoRegE & ((RtE == RsD) | (RtE == RtD));
    br_stall  = BranchD &
                ((RegWriteE & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
                 (MemtoRegM & ((WriteRegM == RsD) | (WriteRegM == RtD))));
    md_stall  = MdOpD & md_busy;
  end

  // Forwarding selects: MEM result beats WB result, r0 never forwards.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!rst) begin
      if (RsE != 5'd0 && RegWriteM && WriteRegM == RsE)
        ForwardAE = 2'b10;
      else if (RsE != 5'd0 && RegWriteW && WriteRegW == RsE)
        ForwardAE = 2'b01;
      if (RtE != 5'd0 && RegWriteM && WriteRegM == RtE)
        ForwardBE = 2'b10;
      else if (RtE != 5'd0 && RegWriteW && WriteRegW == RtE)
        ForwardBE = 2'b01;
      ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
      ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);
    end
  end

  // FSM next state plus stall decode: a memory wait freezes everything
  // without a bubble, otherwise an ID hazard holds IF/ID and bubbles EX.
  always_comb begin
    state_next = state;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushE     = 1'b0;
    case (state)
      RUN:      if (mem_stall)  state_next = MEM_WAIT;
      MEM_WAIT: if (!mem_stall) state_next = RUN;
      default:  state_next = RUN;
    endcase
    if (!rst) begin
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (lw_stall | br_stall | md_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Count consecutive wait cycles; cleared whenever the pipeline is running.
  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (state == RUN)
      wait_cnt <= '0;
    else if (wait_cnt != WAIT_MAX)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky timeout flag, only cleared by reset.
  always_ff @(posedge clk) begin
    if (rst)
      mem_err <= 1'b0;
    else if (state == MEM_WAIT && mem_stall && wait_cnt >= WAIT_LIMIT)
      mem_err <= 1'b1;
  end

  // HI/LO occupancy countdown; an issue held by a memory stall does not load.
  always_ff @(posedge clk) begin
    if (rst)
      md_cnt <= 4'd0;
    else if (MdStartE && !StallE)
      md_cnt <= MD_LOAD;
    else if (md_cnt != 4'd0)
      md_cnt <= md_cnt - 4'd1;
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Testbench for hazard_sched: directed scenario tasks plus a randomized run
// compared against a cycle-count based reference model.
module tb_hazard_sched;

  localparam int MD_LAT = 4;
  localparam int MEM_TO = 8;

  logic       clk;
  logic       rst;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, MdOpD, MdStartE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushE, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MdBusy, MemErr;
  logic [12:0] obs;

  int checks = 0;
  int errors = 0;

  // Reference model state: absolute cycle count, cycle at which HI/LO frees,
  // length of the current memory-wait streak and the sticky error flag.
  int cyc      = 0;
  int md_until = 0;
  int streak   = 0;
  bit err_m    = 1'b0;

  hazard_sched #(.MD_LATENCY(MD_LAT), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .MdOpD(MdOpD), .MdStartE(MdStartE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MdBusy(MdBusy), .MemErr(MemErr)
  );

  assign obs = {StallF, StallD, StallE, StallM, FlushE, ForwardAD, ForwardBD,
                ForwardAE, ForwardBE, MdBusy, MemErr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got time %0t, required finish before it", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Which source a register read should take given the producers in MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (RegWriteM && WriteRegM == r) return 2'b10;
    if (RegWriteW && WriteRegW == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [12:0] model_expect();
    logic       busy, mem, hz, fl;
    logic [3:0] st;
    busy = (cyc < md_until);
    mem  = MemReqM && !MemReadyM;
    hz   = (MemtoRegE && (RtE == RsD || RtE == RtD)) ||
           (BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                        (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)))) ||
           (MdOpD && busy);
    if (rst) return {11'b0, busy, err_m};
    st = 4'b0000;
    fl = 1'b0;
    if (mem)     st = 4'b1111;
    else if (hz) begin st = 4'b1100; fl = 1'b1; end
    return {st, fl, fwd_sel(RsD) == 2'b10, fwd_sel(RtD) == 2'b10,
            fwd_sel(RsE), fwd_sel(RtE), busy, err_m};
  endfunction

  // Advance the model with the inputs present at this edge, then clock.
  task automatic tick();
    logic mem;
    mem = MemReqM && !MemReadyM;
    if (rst) begin
      md_until = 0;
      streak   = 0;
      err_m    = 1'b0;
    end else begin
      if (MdStartE && !mem) md_until = cyc + MD_LAT;
      streak = mem ? streak + 1 : 0;
      if (streak > MEM_TO) err_m = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0;
    RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
    WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0; BranchD = 1'b0;
    MdOpD = 1'b0; MdStartE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    MemReqM = 1'b1; MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5; BranchD = 1'b1;
    RegWriteM = 1'b1; WriteRegM = 5'd3; RsE = 5'd3;
    RegWriteW = 1'b1; WriteRegW = 5'd5;
    #1;
    checks++;
    if (obs[12:2] !== 11'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b required %b", obs[12:2], 11'b0);
    end
    tick();
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b required %b", obs, 13'b0);
    end
    clear_inputs();
    #1;
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got %b required %b", obs, 13'b0);
    end
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    RegWriteM = 1'b1; WriteRegM = 5'd3; RegWriteW = 1'b1; WriteRegW = 5'd4;
    RsE = 5'd3; RtE = 5'd4; RsD = 5'd3; RtD = 5'd4;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL fwd_alu: got AE=%b BE=%b required AE=10 BE=01", ForwardAE, ForwardBE);
    end
    checks++;
    if ({ForwardAD, ForwardBD} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL fwd_branch_src: got AD=%b BD=%b required AD=1 BD=0", ForwardAD, ForwardBD);
    end
    WriteRegW = 5'd3;
    RtE = 5'd3;
    #1;
    checks++;
    if (ForwardBE !== 2'b10) begin
      errors++;
      $display("[TB] FAIL fwd_mem_priority: got %b required 10", ForwardBE);
    end
    RsE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd4; RtE = 5'd4;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL fwd_r0: got AE=%b BE=%b required AE=00 BE=01", ForwardAE, ForwardBE);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5; RtE = 5'd5; RsD = 5'd5;
    #1;
    checks++;
    if (obs[12:8] !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL load_use_stall: got %b required 11001", obs[12:8]);
    end
    tick();
    clear_inputs();
    MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd5; RsE = 5'd5;
    #1;
    checks++;
    if ({obs[12:8], ForwardAE} !== 7'b0000010) begin
      errors++;
      $display("[TB] FAIL load_use_release: got stall=%b AE=%b required stall=00000 AE=10", obs[12:8], ForwardAE);
    end
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    BranchD = 1'b1; RsD = 5'd7; RegWriteE = 1'b1; WriteRegE = 5'd7;
    #1;
    checks++;
    if (obs[12:8] !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL branch_stall: got %b required 11001", obs[12:8]);
    end
    tick();
    RegWriteE = 1'b0; WriteRegE = 5'd0; RegWriteM = 1'b1; WriteRegM = 5'd7;
    #1;
    checks++;
    if ({obs[12:8], ForwardAD} !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL branch_forward: got stall=%b AD=%b required stall=00000 AD=1", obs[12:8], ForwardAD);
    end
    MemtoRegM = 1'b1;
    #1;
    checks++;
    if (obs[12:8] !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL branch_load_stall: got %b required 11001", obs[12:8]);
    end
    tick();
  endtask

  task automatic test_muldiv();
    clear_inputs();
    MdStartE = 1'b1;
    #1;
    checks++;
    if (MdBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL md_idle: got %b required 0", MdBusy);
    end
    tick();
    MdStartE = 1'b0;
    MdOpD = 1'b1;
    for (int k = 1; k <= MD_LAT; k++) begin
      logic [3:0] exp;
      exp = (k < MD_LAT) ? 4'b1111 : 4'b0000;
      #1;
      checks++;
      if ({MdBusy, StallF, StallD, FlushE} !== exp) begin
        errors++;
        $display("[TB] FAIL md_cycle%0d: got busy/F/D/flush=%b required %b", k,
                 {MdBusy, StallF, StallD, FlushE}, exp);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    MemReqM = 1'b1; MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (obs[12:8] !== 5'b11110) begin
        errors++;
        $display("[TB] FAIL mem_wait%0d: got %b required 11110", k, obs[12:8]);
      end
      tick();
    end
    MemReadyM = 1'b1;
    #1;
    checks++;
    if (obs[12:8] !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL mem_ready: got %b required 11001", obs[12:8]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if ({obs[12:8], MemErr} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL mem_done: got stall=%b err=%b required all 0", obs[12:8], MemErr);
    end
    tick();
  endtask

  task automatic test_timeout();
    clear_inputs();
    MemReqM = 1'b1;
    // One RUN cycle plus MEM_TO wait cycles before the flag is visible.
    for (int k = 0; k < 10; k++) begin
      logic exp;
      exp = (k >= MEM_TO + 1);
      #1;
      checks++;
      if ({StallM, MemErr} !== {1'b1, exp}) begin
        errors++;
        $display("[TB] FAIL timeout_cycle%0d: got stallM=%b err=%b required stallM=1 err=%b",
                 k, StallM, MemErr, exp);
      end
      tick();
    end
    MemReadyM = 1'b1;
    #1;
    checks++;
    if ({obs[12:9], MemErr} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL timeout_ready: got stall=%b err=%b required 0000 1", obs[12:9], MemErr);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (MemErr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_sticky: got %b required 1", MemErr);
    end
    tick();
    MemReqM = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (obs[12:2] !== 11'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_stall: got %b required %b", obs[12:2], 11'b0);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({obs[12:9], MemErr} !== 5'b11110) begin
      errors++;
      $display("[TB] FAIL reset_clears_err: got stall=%b err=%b required 1111 0", obs[12:9], MemErr);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [12:0] exp;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      RsD       = 5'($urandom_range(0, 3));
      RtD       = 5'($urandom_range(0, 3));
      RsE       = 5'($urandom_range(0, 3));
      RtE       = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = ($urandom_range(0, 1) == 1);
      RegWriteM = ($urandom_range(0, 1) == 1);
      RegWriteW = ($urandom_range(0, 1) == 1);
      MemtoRegE = ($urandom_range(0, 3) == 0);
      MemtoRegM = ($urandom_range(0, 3) == 0);
      BranchD   = ($urandom_range(0, 3) == 0);
      MdOpD     = ($urandom_range(0, 2) == 0);
      MdStartE  = ($urandom_range(0, 7) == 0);
      MemReqM   = ($urandom_range(0, 1) == 1);
      MemReadyM = ($urandom_range(0, 3) != 0);
      if (i >= 200 && i < 216) begin
        rst       = 1'b0;
        MemReqM   = 1'b1;
        MemReadyM = 1'b0;
      end
      #1;
      exp = model_expect();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: got %b required %b", i, obs, exp);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_muldiv();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
